// File: rtl/acc_row_buffer.sv
// acc_row_buffer: DEPTH-row x LANES signed accumulation FIFO with LOAD/DRAIN handshakes.
// Define ACC_ROW_BUFFER_SATURATE_EN to clamp accumulates per lane and drive the sticky acc_sat flag.
module acc_row_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic                         wr_acc,
  input  logic [LANES*DATA_WIDTH-1:0]  wr_data,
  output logic                         wr_ready,
  input  logic                         drain_start,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [LANES*DATA_WIDTH-1:0]  rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         acc_sat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = DATA_WIDTH;
  localparam int RW = LANES * DATA_WIDTH;

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, acc_off_q, acc_off_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic [RW-1:0]   rd_data_q, rd_data_d;
  logic [RW-1:0]   mem_q [DEPTH];

  logic            mem_we;
  logic [PW-1:0]   mem_waddr;
  logic [RW-1:0]   mem_wdata;
  logic [PW:0]     acc_sum_idx;
  logic [PW-1:0]   acc_idx;
  logic [RW-1:0]   acc_old, acc_row;
  logic            store_fire, acc_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ready   = (state_q == LOAD) && (wr_acc ? (count_q != '0) : (count_q != CW'(DEPTH)));
  assign store_fire = wr_valid && wr_ready && !wr_acc;
  assign acc_fire   = wr_valid && wr_ready && wr_acc;

  // Accumulate target is acc_off rows past head, modulo DEPTH (DEPTH need not be a power of two).
  assign acc_sum_idx = {1'b0, head_q} + {1'b0, acc_off_q};
  assign acc_idx     = (acc_sum_idx >= (PW+1)'(DEPTH)) ? PW'(acc_sum_idx - (PW+1)'(DEPTH))
                                                       : acc_sum_idx[PW-1:0];
  assign acc_old     = mem_q[acc_idx];

`ifdef ACC_ROW_BUFFER_SATURATE_EN
  logic          acc_clamp;
  logic [DW:0]   lane_sum;
  logic          acc_sat_q, acc_sat_d;

  always_comb begin
    acc_row   = '0;
    acc_clamp = 1'b0;
    lane_sum  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {acc_old[i*DW+DW-1], acc_old[i*DW +: DW]} + {wr_data[i*DW+DW-1], wr_data[i*DW +: DW]};
      if (lane_sum[DW] != lane_sum[DW-1]) begin
        acc_clamp           = 1'b1;
        acc_row[i*DW +: DW] = lane_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        acc_row[i*DW +: DW] = lane_sum[DW-1:0];
      end
    end
  end

  always_comb begin
    acc_sat_d = acc_sat_q | (acc_fire & acc_clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_sat_q <= 1'b0;
    else     acc_sat_q <= acc_sat_d;
  end

  assign acc_sat = acc_sat_q;
`else
  always_comb begin
    acc_row = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_row[i*DW +: DW] = acc_old[i*DW +: DW] + wr_data[i*DW +: DW];
    end
  end

  assign acc_sat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    acc_off_d  = acc_off_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_waddr  = tail_q;
    mem_wdata  = wr_data;
    unique case (state_q)
      LOAD: begin
        if (store_fire) begin
          mem_we    = 1'b1;
          tail_d    = ptr_inc(tail_q);
          count_d   = count_q + CW'(1);
          acc_off_d = '0;
        end else if (acc_fire) begin
          mem_we    = 1'b1;
          mem_waddr = acc_idx;
          mem_wdata = acc_row;
          acc_off_d = (CW'(acc_off_q) + CW'(1) == count_q) ? '0 : acc_off_q + PW'(1);
        end
        // Uses the pre-write count, so a write in the same cycle still lands before the drain.
        if (drain_start && count_q != '0) state_d = DRAIN;
      end
      DRAIN: begin
        if ((!rd_valid_q || rd_ready) && count_q != '0) begin
          rd_data_d  = mem_q[head_q];
          rd_valid_d = 1'b1;
          head_d     = ptr_inc(head_q);
          count_d    = count_q - CW'(1);
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = LOAD;
          acc_off_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      head_q     <= '0;
      tail_q     <= '0;
      acc_off_q  <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      acc_off_q  <= acc_off_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign busy     = (state_q == DRAIN);

endmodule

// File: tb/tb_acc_row_buffer.sv
// tb_acc_row_buffer: directed table, corner-case sequences and randomized traffic against a queue model.
// Expected saturation results follow ACC_ROW_BUFFER_SATURATE_EN when it is defined for the build.
module tb_acc_row_buffer;
  localparam int DW    = 16;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_acc;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        drain_start;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [2:0]  count;
  logic        busy;
  logic        acc_sat;

  int total = 0;
  int bad   = 0;

  acc_row_buffer #(.DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_acc(wr_acc), .wr_data(wr_data),
    .wr_ready(wr_ready), .drain_start(drain_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .busy(busy), .acc_sat(acc_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored rows as a queue (front = oldest), plus the drain-side view.
  logic [31:0] mq[$];
  bit          m_busy;
  bit          m_rv;
  logic [31:0] m_rd;
  int          m_off;
  bit          m_sat;

  function automatic void acc_lane(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output bit clamp);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
    clamp = 1'b0;
`ifdef ACC_ROW_BUFFER_SATURATE_EN
    if (s > 32767) begin
      r = 16'h7FFF;
      clamp = 1'b1;
    end else if (s < -32768) begin
      r = 16'h8000;
      clamp = 1'b1;
    end else begin
      r = s[15:0];
    end
`else
    r = s[15:0];
`endif
  endfunction

  task automatic model_step();
    int cnt;
    logic [31:0] r;
    logic [15:0] l0, l1;
    bit c0, c1;
    cnt = mq.size();
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_rd   = '0;
      m_off  = 0;
      m_sat  = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (wr_valid && !wr_acc && cnt < DEPTH) begin
        mq.push_back(wr_data);
        m_off = 0;
      end else if (wr_valid && wr_acc && cnt > 0) begin
        r = mq[m_off];
        acc_lane(r[15:0], wr_data[15:0], l0, c0);
        acc_lane(r[31:16], wr_data[31:16], l1, c1);
        mq[m_off] = {l1, l0};
        if (c0 || c1) m_sat = 1'b1;
        m_off = (m_off + 1 == cnt) ? 0 : m_off + 1;
      end
      if (drain_start && cnt > 0) m_busy = 1'b1;
    end else begin
      if ((!m_rv || rd_ready) && cnt > 0) begin
        m_rd = mq.pop_front();
        m_rv = 1'b1;
      end else if (m_rv && rd_ready) begin
        m_rv   = 1'b0;
        m_busy = 1'b0;
        m_off  = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    bit exp_wrr;
    exp_wrr = !m_busy && (wr_acc ? (mq.size() > 0) : (mq.size() < DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", rd_data, m_rd);
    chk("count", 32'(count), 32'(mq.size()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("acc_sat", 32'(acc_sat), 32'(m_sat));
    chk("wr_ready", 32'(wr_ready), 32'(exp_wrr));
  endtask

  typedef struct {
    int          rst, wv, wa;
    logic [31:0] wd;
    int          ds, rr;
    int          exp_wrr, exp_cnt, exp_rv;
    logic [31:0] exp_rd;
    int          exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, input int wv, input int wa, input logic [31:0] wd,
                              input int ds, input int rr, input int ewrr, input int ecnt,
                              input int erv, input logic [31:0] erd, input int ebusy);
    vec_t v;
    v.rst = r; v.wv = wv; v.wa = wa; v.wd = wd; v.ds = ds; v.rr = rr;
    v.exp_wrr = ewrr; v.exp_cnt = ecnt; v.exp_rv = erv; v.exp_rd = erd; v.exp_busy = ebusy;
    return v;
  endfunction

  // wr_ready is checked before the edge; everything else after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    rst         = v.rst[0];
    wr_valid    = v.wv[0];
    wr_acc      = v.wa[0];
    wr_data     = v.wd;
    drain_start = v.ds[0];
    rd_ready    = v.rr[0];
    #1;
    tag = $sformatf("vec%0d", idx);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(v.exp_wrr));
    cycle();
    chk({tag, "_count"}, 32'(count), 32'(v.exp_cnt));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(v.exp_rv));
    chk({tag, "_rd_data"}, rd_data, v.exp_rd);
    chk({tag, "_busy"}, 32'(busy), 32'(v.exp_busy));
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_acc = 1'b0; drain_start = 1'b0; rd_ready = 1'b0; wr_data = '0;
  endtask

  task automatic storeRow(input logic [31:0] d);
    wr_valid = 1'b1; wr_acc = 1'b0; wr_data = d;
    cycle();
    checkOutput();
    wr_valid = 1'b0;
  endtask

  // Pulses drain_start with rd_ready high and collects every row until busy drops.
  task automatic drainAll(input string name, input logic [31:0] exp_rows[$]);
    logic [31:0] got[$];
    bit done;
    done = 1'b0;
    drain_start = 1'b1; rd_ready = 1'b1;
    cycle();
    checkOutput();
    drain_start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      checkOutput();
      if (rd_valid) got.push_back(rd_data);
      if (!busy) done = 1'b1;
    end
    rd_ready = 1'b0;
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
    chk({name, "_rows"}, 32'(got.size()), 32'(exp_rows.size()));
    for (int i = 0; i < exp_rows.size() && i < got.size(); i++)
      chk($sformatf("%s_row%0d", name, i), got[i], exp_rows[i]);
  endtask

  initial begin
    logic [31:0] exp_rows[$];
    logic [31:0] sat_row;
    int          sat_flag;

    idle();
    rst = 1'b1;
    mq.delete(); m_busy = 0; m_rv = 0; m_rd = '0; m_off = 0; m_sat = 0;

    $display("[TB] reset check");
    cycle();
    cycle();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc_sat", 32'(acc_sat), 32'd0);
    chk("rst_wr_ready_store", 32'(wr_ready), 32'd1);
    wr_acc = 1'b1;
    #1;
    chk("rst_wr_ready_acc", 32'(wr_ready), 32'd0);
    wr_acc = 1'b0;
    rst = 1'b0;

    // Fill to full, blocked fifth store, in-order drain; then K-tiling accumulate with offset wrap.
    vecs.push_back(mk(0,1,0,32'h0002_0001,0,0, 1,1,0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0004_0003,0,0, 1,2,0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0006_0005,0,0, 1,3,0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0008_0007,0,0, 1,4,0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0009_0009,0,0, 0,4,0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,1,1, 0,4,0,32'h0,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,3,1,32'h0002_0001,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,2,1,32'h0004_0003,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,1,1,32'h0006_0005,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,0,1,32'h0008_0007,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,0,0,32'h0008_0007,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0, 1,0,0,32'h0008_0007,0));
    vecs.push_back(mk(0,1,0,32'h0002_0001,0,0, 1,1,0,32'h0008_0007,0));
    vecs.push_back(mk(0,1,0,32'h0004_0003,0,0, 1,2,0,32'h0008_0007,0));
    vecs.push_back(mk(0,1,1,32'h000A_000A,0,0, 1,2,0,32'h0008_0007,0));
    vecs.push_back(mk(0,1,1,32'h000A_000A,0,0, 1,2,0,32'h0008_0007,0));
    vecs.push_back(mk(0,1,1,32'h000A_000A,0,0, 1,2,0,32'h0008_0007,0));
    vecs.push_back(mk(0,0,0,32'h0,1,1, 1,2,0,32'h0008_0007,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,1,1,32'h0016_0015,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,0,1,32'h000E_000D,1));
    vecs.push_back(mk(0,0,0,32'h0,0,1, 0,0,0,32'h000E_000D,0));

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    idle();

    $display("[TB] saturation corner");
`ifdef ACC_ROW_BUFFER_SATURATE_EN
    sat_row = 32'h8000_7FFF; sat_flag = 1;
`else
    sat_row = 32'h7FF0_8010; sat_flag = 0;
`endif
    storeRow(32'h8010_7FF0);
    wr_valid = 1'b1; wr_acc = 1'b1; wr_data = 32'hFFE0_0020;
    cycle();
    checkOutput();
    idle();
    exp_rows = '{sat_row};
    drainAll("sat", exp_rows);
    chk("sat_flag", 32'(acc_sat), 32'(sat_flag));

    $display("[TB] stall then reset mid-drain");
    storeRow(32'h1111_0001);
    storeRow(32'h2222_0002);
    storeRow(32'h3333_0003);
    drain_start = 1'b1; rd_ready = 1'b0;
    cycle();
    checkOutput();
    drain_start = 1'b0;
    cycle();
    checkOutput();
    chk("stall_first_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput();
      chk($sformatf("stall%0d_rd_data", i), rd_data, 32'h1111_0001);
      chk($sformatf("stall%0d_count", i), 32'(count), 32'd2);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    checkOutput();

    $display("[TB] empty drain and pointer wrap");
    drain_start = 1'b1;
    cycle();
    checkOutput();
    chk("empty_drain_busy", 32'(busy), 32'd0);
    drain_start = 1'b0;
    storeRow(32'hA001_0001);
    storeRow(32'hA002_0002);
    exp_rows = '{32'hA001_0001, 32'hA002_0002};
    drainAll("wrap_a", exp_rows);
    storeRow(32'hB003_0003);
    storeRow(32'hB004_0004);
    storeRow(32'hB005_0005);
    storeRow(32'hB006_0006);
    exp_rows = '{32'hB003_0003, 32'hB004_0004, 32'hB005_0005, 32'hB006_0006};
    drainAll("wrap_b", exp_rows);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      wr_valid    = $urandom_range(0, 1) == 1;
      wr_acc      = $urandom_range(0, 2) == 0;
      wr_data     = $urandom();
      drain_start = $urandom_range(0, 7) == 0;
      rd_ready    = $urandom_range(0, 3) != 0;
      cycle();
      checkOutput();
    end
    rst = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
